// File: rtl/llama_layer_div_pkg.sv
// Shared types and constants for the llama_layer sequential signed divider.
// Holds the FSM state encoding and the default operand widths.
package llama_layer_div_pkg;

    localparam int DW    = 36;
    localparam int DSW   = 10;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } div_state_t;

    typedef logic signed [DW-1:0]  dividend_t;
    typedef logic signed [DSW-1:0] divisor_t;
    typedef logic        [DW-1:0]  mag_t;
    typedef logic        [DSW-1:0] dmag_t;

    // Two's-complement magnitude; the most negative value maps to 2^(DW-1).
    function automatic mag_t abs_dividend(input dividend_t v);
        return v[DW-1] ? mag_t'(-v) : mag_t'(v);
    endfunction

    // Magnitude of the divisor; -2^(DSW-1) maps to 2^(DSW-1), still DSW bits.
    function automatic dmag_t abs_divisor(input divisor_t v);
        return v[DSW-1] ? dmag_t'(-v) : dmag_t'(v);
    endfunction

endpackage

// File: rtl/llama_layer_div_step.sv
// One radix-2 restoring division step.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module llama_layer_div_step
    import llama_layer_div_pkg::*;
#(
    parameter int DSW_P = DSW
) (
    input  logic [DSW_P:0]   p_in,
    input  logic             dbit,
    input  logic [DSW_P-1:0] dmag,
    output logic [DSW_P:0]   p_out,
    output logic             q_bit
);

    logic [DSW_P+1:0] trial;
    logic [DSW_P+1:0] diff;

    assign trial = {p_in, dbit};
    assign diff  = trial - {2'b00, dmag};

    // Keep the difference only when the divisor fits into the shifted remainder.
    always_comb begin
        p_out = trial[DSW_P:0];
        q_bit = 1'b0;
        if (trial >= {2'b00, dmag}) begin
            p_out = diff[DSW_P:0];
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/llama_layer_sdiv_36s_10s_36_seq.sv
// Sequential signed divider: 36-bit dividend by 10-bit divisor.
// One quotient bit per cycle, sign fix-up and exception flags in a final cycle.
module llama_layer_sdiv_36s_10s_36_seq
    import llama_layer_div_pkg::*;
#(
    parameter int ID             = 1,
    parameter int DIVIDEND_WIDTH = DW,
    parameter int DIVISOR_WIDTH  = DSW
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] dout,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int W  = DIVIDEND_WIDTH;
    localparam int S  = DIVISOR_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] QMAX = ~QMIN;
    localparam logic [S-1:0] NEG1 = '1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    // The instance tag carries no function; it only names the instance.
    if (ID < 0) begin : g_id_tag
    end

    div_state_t     state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   q_sh;
    logic [S-1:0]   d_mag;
    logic [S:0]     p;
    logic           sgn_a;
    logic           sgn_b;
    logic           zero_d;
    logic           ovf_d;

    logic [W-1:0]   a_mag;
    logic [S-1:0]   b_mag;
    logic [S:0]     p_nxt;
    logic           q_bit;
    logic [S:0]     p_neg;

    // Operand magnitudes, unsigned so the most negative inputs still fit.
    always_comb begin
        a_mag = din0[W-1] ? (~din0 + 1'b1) : din0;
        b_mag = din1[S-1] ? (~din1 + 1'b1) : din1;
    end

    assign p_neg    = ~p + 1'b1;
    assign in_ready = (state == IDLE);

    llama_layer_div_step #(
        .DSW_P (S)
    ) u_step (
        .p_in  (p),
        .dbit  (q_sh[W-1]),
        .dmag  (d_mag),
        .p_out (p_nxt),
        .q_bit (q_bit)
    );

    // Control FSM; q_sh shifts dividend bits out the top and quotient bits in.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_sh        <= '0;
            d_mag       <= '0;
            p           <= '0;
            sgn_a       <= 1'b0;
            sgn_b       <= 1'b0;
            zero_d      <= 1'b0;
            ovf_d       <= 1'b0;
            out_valid   <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sh   <= a_mag;
                        d_mag  <= b_mag;
                        p      <= '0;
                        sgn_a  <= din0[W-1];
                        sgn_b  <= din1[S-1];
                        zero_d <= (din1 == '0);
                        ovf_d  <= (din0 == QMIN) && (din1 == NEG1);
                        cnt    <= '0;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    p    <= p_nxt;
                    q_sh <= {q_sh[W-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_d) begin
                        dout <= sgn_a ? QMIN : QMAX;
                        rem  <= '0;
                    end else begin
                        dout <= (sgn_a ^ sgn_b) ? (~q_sh + 1'b1) : q_sh;
                        rem  <= sgn_a ? p_neg[S-1:0] : p[S-1:0];
                    end
                    div_by_zero <= zero_d;
                    overflow    <= ovf_d & ~p[S];
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
